// File: rtl/qbu_rx_pkg.sv
// Shared Qbu receive-path definitions: SMD codes, CRC status codes, frame classes,
// router FSM states and user-field bit positions.
package qbu_rx_pkg;

   localparam logic [7:0] SMD_E  = 8'hD5;
   localparam logic [7:0] SMD_R  = 8'h19;
   localparam logic [7:0] SMD_V  = 8'h07;
   localparam logic [7:0] SMD_P0 = 8'hE6;
   localparam logic [7:0] SMD_P1 = 8'h4C;
   localparam logic [7:0] SMD_P2 = 8'h7F;
   localparam logic [7:0] SMD_P3 = 8'hB3;
   localparam logic [7:0] SMD_P4 = 8'h61;
   localparam logic [7:0] SMD_P5 = 8'h52;
   localparam logic [7:0] SMD_P6 = 8'h9E;
   localparam logic [7:0] SMD_P7 = 8'h2A;

   localparam logic [1:0] CRC  = 2'b01;
   localparam logic [1:0] MCRC = 2'b10;

   localparam int USR_INFO_VLD = 15;
   localparam int USR_SMD_MSB  = 14;
   localparam int USR_SMD_LSB  = 7;
   localparam int USR_CRC_MSB  = 4;
   localparam int USR_CRC_LSB  = 3;

   typedef enum logic [2:0] {CLS_E, CLS_P, CLS_R, CLS_V, CLS_NONE} cls_e;

   typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} rt_state_e;

   function automatic logic is_p_smd(input logic [7:0] smd);
      return (smd == SMD_P0) || (smd == SMD_P1) || (smd == SMD_P2) || (smd == SMD_P3) ||
             (smd == SMD_P4) || (smd == SMD_P5) || (smd == SMD_P6) || (smd == SMD_P7);
   endfunction

endpackage

// File: rtl/qbu_rx_frame_router_if.sv
// Router stream bundle: one input AXI-Stream plus NUM_CH packed output channels.
// slave = router side, master = upstream/consumer side.
interface qbu_rx_frame_router_if #(
   parameter int DWIDTH = 8,
   parameter int NUM_CH = 4
);
   logic [DWIDTH-1:0]          i_rx_axis_data;
   logic [15:0]                i_rx_axis_user;
   logic [DWIDTH/8-1:0]        i_rx_axis_keep;
   logic                       i_rx_axis_last;
   logic                       i_rx_axis_valid;
   logic [11:0]                i_data_len;
   logic                       o_rx_axis_ready;
   logic [NUM_CH*DWIDTH-1:0]   o_ch_axis_data;
   logic [NUM_CH*16-1:0]       o_ch_axis_user;
   logic [NUM_CH*DWIDTH/8-1:0] o_ch_axis_keep;
   logic [NUM_CH-1:0]          o_ch_axis_last;
   logic [NUM_CH-1:0]          o_ch_axis_valid;
   logic [NUM_CH-1:0]          i_ch_axis_ready;

   modport slave (
      input  i_rx_axis_data, i_rx_axis_user, i_rx_axis_keep, i_rx_axis_last,
             i_rx_axis_valid, i_data_len, i_ch_axis_ready,
      output o_rx_axis_ready, o_ch_axis_data, o_ch_axis_user, o_ch_axis_keep,
             o_ch_axis_last, o_ch_axis_valid
   );

   modport master (
      output i_rx_axis_data, i_rx_axis_user, i_rx_axis_keep, i_rx_axis_last,
             i_rx_axis_valid, i_data_len, i_ch_axis_ready,
      input  o_rx_axis_ready, o_ch_axis_data, o_ch_axis_user, o_ch_axis_keep,
             o_ch_axis_last, o_ch_axis_valid
   );
endinterface

// File: rtl/qbu_rx_smd_classify.sv
// Combinational SMD/CRC classifier: user-field subfields -> frame class, no latency.
module qbu_rx_smd_classify
   import qbu_rx_pkg::*;
(
   input  logic       info_vld_i,
   input  logic [7:0] smd_i,
   input  logic [1:0] crc_i,
   output cls_e       cls_o
);

   always_comb begin
      cls_o = CLS_NONE;
      if (info_vld_i) begin
         if (smd_i == SMD_E && crc_i == CRC)
            cls_o = CLS_E;
         else if (smd_i == SMD_R && crc_i == CRC)
            cls_o = CLS_R;
         else if (smd_i == SMD_V && crc_i == CRC)
            cls_o = CLS_V;
         else if (is_p_smd(smd_i) && (crc_i == CRC || crc_i == MCRC))
            cls_o = CLS_P;
      end
   end

endmodule

// File: rtl/qbu_rx_frame_router.sv
// Qbu RX frame router: classify on the first beat, steer the whole frame to one channel, 1-cycle registered output.
// Backpressure only from the channel owning the output register; counters added under QBU_RX_ROUTER_STATS_EN.
module qbu_rx_frame_router
   import qbu_rx_pkg::*;
#(
   parameter int         DWIDTH = 8,
   parameter int         NUM_CH = 4,
   parameter logic [7:0] CH_MAP = 8'b11_10_01_00
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   qbu_rx_frame_router_if.slave   bus,
   output logic                   o_drop_pulse
`ifdef QBU_RX_ROUTER_STATS_EN
   ,
   output logic [NUM_CH*32-1:0]   o_frm_cnt,
   output logic [31:0]            o_drop_cnt
`endif
);

   localparam int KW = DWIDTH / 8;

   rt_state_e         state_q;
   logic [1:0]        sel_q;
   logic              pass_q;
   logic              drop_pulse_q;

   logic              out_vld_q, out_vld_d;
   logic [1:0]        out_sel_q, out_sel_d;
   logic [DWIDTH-1:0] out_dat_q, out_dat_d;
   logic [15:0]       out_user_q, out_user_d;
   logic [KW-1:0]     out_keep_q, out_keep_d;
   logic              out_last_q, out_last_d;

   cls_e              cls;
   logic [1:0]        cls_ch;
   logic              cls_mapped;
   logic              cur_fwd, cur_pass;
   logic [1:0]        cur_sel;
   logic [3:0]        ch_rdy;
   logic              drain, rx_rdy, accept, load, drop_last;

   qbu_rx_smd_classify u_classify (
      .info_vld_i (bus.i_rx_axis_user[USR_INFO_VLD]),
      .smd_i      (bus.i_rx_axis_user[USR_SMD_MSB:USR_SMD_LSB]),
      .crc_i      (bus.i_rx_axis_user[USR_CRC_MSB:USR_CRC_LSB]),
      .cls_o      (cls)
   );

   always_comb begin
      cls_ch = 2'd0;
      case (cls)
         CLS_E:   cls_ch = CH_MAP[1:0];
         CLS_P:   cls_ch = CH_MAP[3:2];
         CLS_R:   cls_ch = CH_MAP[5:4];
         CLS_V:   cls_ch = CH_MAP[7:6];
         default: cls_ch = 2'd0;
      endcase
      cls_mapped = (cls != CLS_NONE) && ({30'd0, cls_ch} < 32'(NUM_CH));
   end

   // In IDLE the live classification steers the beat; mid-frame the latched decision does.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_fwd  = cls_mapped;
         cur_sel  = cls_ch;
         cur_pass = (cls == CLS_P);
      end else begin
         cur_fwd  = (state_q == ST_FWD);
         cur_sel  = sel_q;
         cur_pass = pass_q;
      end
   end

   always_comb begin
      ch_rdy = '0;
      for (int k = 0; k < NUM_CH; k++)
         ch_rdy[k] = bus.i_ch_axis_ready[k];
   end

   // Readiness follows the channel holding the register, so a switch of channel waits for its drain.
   assign drain     = out_vld_q & ch_rdy[out_sel_q];
   assign rx_rdy    = ~cur_fwd | ~out_vld_q | ch_rdy[out_sel_q];
   assign accept    = bus.i_rx_axis_valid & rx_rdy;
   assign load      = accept & cur_fwd;
   assign drop_last = accept & ~cur_fwd & bus.i_rx_axis_last;

   always_comb begin
      out_vld_d  = out_vld_q;
      out_sel_d  = out_sel_q;
      out_dat_d  = out_dat_q;
      out_user_d = out_user_q;
      out_keep_d = out_keep_q;
      out_last_d = out_last_q;
      if (load) begin
         out_vld_d  = 1'b1;
         out_sel_d  = cur_sel;
         out_dat_d  = bus.i_rx_axis_data;
         out_user_d = cur_pass ? bus.i_rx_axis_user : {4'b0, bus.i_data_len};
         out_keep_d = bus.i_rx_axis_keep;
         out_last_d = bus.i_rx_axis_last;
      end else if (drain) begin
         out_vld_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         out_vld_q    <= 1'b0;
         out_sel_q    <= 2'd0;
         out_dat_q    <= '0;
         out_user_q   <= '0;
         out_keep_q   <= '0;
         out_last_q   <= 1'b0;
         drop_pulse_q <= 1'b0;
      end else begin
         out_vld_q    <= out_vld_d;
         out_sel_q    <= out_sel_d;
         out_dat_q    <= out_dat_d;
         out_user_q   <= out_user_d;
         out_keep_q   <= out_keep_d;
         out_last_q   <= out_last_d;
         drop_pulse_q <= drop_last;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         sel_q   <= 2'd0;
         pass_q  <= 1'b0;
      end else if (accept) begin
         case (state_q)
            ST_IDLE: begin
               sel_q  <= cls_ch;
               pass_q <= (cls == CLS_P);
               if (!bus.i_rx_axis_last)
                  state_q <= cls_mapped ? ST_FWD : ST_DROP;
            end
            default: begin
               if (bus.i_rx_axis_last)
                  state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus.o_ch_axis_data  = '0;
      bus.o_ch_axis_user  = '0;
      bus.o_ch_axis_keep  = '0;
      bus.o_ch_axis_last  = '0;
      bus.o_ch_axis_valid = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (out_vld_q && {30'd0, out_sel_q} == 32'(k)) begin
            bus.o_ch_axis_data[k*DWIDTH +: DWIDTH] = out_dat_q;
            bus.o_ch_axis_user[k*16 +: 16]         = out_user_q;
            bus.o_ch_axis_keep[k*KW +: KW]         = out_keep_q;
            bus.o_ch_axis_last[k]                  = out_last_q;
            bus.o_ch_axis_valid[k]                 = 1'b1;
         end
      end
   end

   assign bus.o_rx_axis_ready = rx_rdy;
   assign o_drop_pulse        = drop_pulse_q;

`ifdef QBU_RX_ROUTER_STATS_EN
   logic [NUM_CH-1:0][31:0] frm_cnt_q;
   logic [31:0]             drop_cnt_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         frm_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++)
            if (drain && out_last_q && {30'd0, out_sel_q} == 32'(k))
               frm_cnt_q[k] <= frm_cnt_q[k] + 32'd1;
         if (drop_last)
            drop_cnt_q <= drop_cnt_q + 32'd1;
      end
   end

   assign o_frm_cnt  = frm_cnt_q;
   assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_qbu_rx_frame_router.sv
// Directed bench for qbu_rx_frame_router: a 4-channel and a 2-channel instance share one input stream.
module tb_qbu_rx_frame_router;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   qbu_rx_frame_router_if #(.DWIDTH(8), .NUM_CH(4)) if4 ();
   qbu_rx_frame_router_if #(.DWIDTH(8), .NUM_CH(2)) if2 ();

   logic drop4, drop2;
`ifdef QBU_RX_ROUTER_STATS_EN
   logic [127:0] frm4;
   logic [31:0]  dcnt4;
   logic [63:0]  frm2;
   logic [31:0]  dcnt2;
`endif

   assign if2.i_rx_axis_data  = if4.i_rx_axis_data;
   assign if2.i_rx_axis_user  = if4.i_rx_axis_user;
   assign if2.i_rx_axis_keep  = if4.i_rx_axis_keep;
   assign if2.i_rx_axis_last  = if4.i_rx_axis_last;
   assign if2.i_rx_axis_valid = if4.i_rx_axis_valid;
   assign if2.i_data_len      = if4.i_data_len;
   assign if2.i_ch_axis_ready = if4.i_ch_axis_ready[1:0];

   qbu_rx_frame_router #(.DWIDTH(8), .NUM_CH(4)) dut4 (
      .i_clk        (clk),
      .i_rst        (rst),
      .bus          (if4.slave),
      .o_drop_pulse (drop4)
`ifdef QBU_RX_ROUTER_STATS_EN
      ,
      .o_frm_cnt    (frm4),
      .o_drop_cnt   (dcnt4)
`endif
   );

   qbu_rx_frame_router #(.DWIDTH(8), .NUM_CH(2)) dut2 (
      .i_clk        (clk),
      .i_rst        (rst),
      .bus          (if2.slave),
      .o_drop_pulse (drop2)
`ifdef QBU_RX_ROUTER_STATS_EN
      ,
      .o_frm_cnt    (frm2),
      .o_drop_cnt   (dcnt2)
`endif
   );

   typedef struct {
      logic [15:0] user;
      logic [15:0] user_mid;
      logic [11:0] len;
      int          nb;
      logic [7:0]  dbase;
      int          ch4;
      int          ch2;
      logic [15:0] uout;
   } vec_t;

   vec_t tbl [15];
   int   checks = 0;
   int   errors = 0;
   int   exp_frm4_0 = 0, exp_frm2_0 = 0, exp_drop4 = 0, exp_drop2 = 0;

   function automatic logic [15:0] mk_user(input logic vld, input logic [7:0] smd, input logic [1:0] crc);
      return {vld, smd, 2'b00, crc, 3'b000};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      if4.i_rx_axis_valid = 1'b0;
      if4.i_rx_axis_last  = 1'b0;
      if4.i_rx_axis_data  = '0;
      if4.i_rx_axis_user  = '0;
      if4.i_rx_axis_keep  = '0;
      if4.i_data_len      = '0;
   endtask

   task automatic drive(input logic [15:0] user, input logic [11:0] len, input logic [7:0] dat, input logic last);
      if4.i_rx_axis_valid = 1'b1;
      if4.i_rx_axis_user  = user;
      if4.i_data_len      = len;
      if4.i_rx_axis_data  = dat;
      if4.i_rx_axis_keep  = 1'b1;
      if4.i_rx_axis_last  = last;
   endtask

   // Expected bus images for one beat parked on channel ch (or nothing when ch < 0).
   task automatic chk_out4(input string tag, input int ch, input logic [7:0] dat,
                           input logic [15:0] usr, input logic last);
      logic [3:0]  ev;
      logic [31:0] ed;
      logic [63:0] eu;
      logic [3:0]  ek, el;
      ev = '0; ed = '0; eu = '0; ek = '0; el = '0;
      if (ch >= 0) begin
         ev[ch] = 1'b1;
         ed[ch*8 +: 8] = dat;
         eu[ch*16 +: 16] = usr;
         ek[ch] = 1'b1;
         el[ch] = last;
      end
      chk({tag, " valid4"}, 64'(if4.o_ch_axis_valid), 64'(ev));
      chk({tag, " data4"},  64'(if4.o_ch_axis_data),  64'(ed));
      chk({tag, " user4"},  if4.o_ch_axis_user,       eu);
      chk({tag, " keep4"},  64'(if4.o_ch_axis_keep),  64'(ek));
      chk({tag, " last4"},  64'(if4.o_ch_axis_last),  64'(el));
   endtask

   task automatic send(input int vi);
      vec_t v;
      logic [1:0] ev2;
      logic last;
      v = tbl[vi];
      for (int i = 0; i < v.nb; i++) begin
         last = (i == v.nb - 1);
         drive((i == 0) ? v.user : v.user_mid, v.len, v.dbase + 8'(i), last);
         #1;
         chk($sformatf("v%0d b%0d ready4", vi, i), 64'(if4.o_rx_axis_ready), 64'd1);
         chk($sformatf("v%0d b%0d ready2", vi, i), 64'(if2.o_rx_axis_ready), 64'd1);
         step();
         chk_out4($sformatf("v%0d b%0d", vi, i), v.ch4, v.dbase + 8'(i), v.uout, last);
         ev2 = '0;
         if (v.ch2 >= 0) ev2[v.ch2] = 1'b1;
         chk($sformatf("v%0d b%0d valid2", vi, i), 64'(if2.o_ch_axis_valid), 64'(ev2));
         chk($sformatf("v%0d b%0d drop4", vi, i), 64'(drop4), 64'(last && v.ch4 < 0));
         chk($sformatf("v%0d b%0d drop2", vi, i), 64'(drop2), 64'(last && v.ch2 < 0));
         if (last) begin
            if (v.ch4 == 0) exp_frm4_0++;
            if (v.ch2 == 0) exp_frm2_0++;
            if (v.ch4 < 0)  exp_drop4++;
            if (v.ch2 < 0)  exp_drop2++;
         end
      end
   endtask

   initial begin
      logic [15:0] pu;

      tbl[0]  = '{mk_user(1, 8'hD5, 2'b01), mk_user(1, 8'hD5, 2'b01), 12'h004, 4, 8'h01,  0,  0, 16'h0004};
      tbl[1]  = '{mk_user(1, 8'h61, 2'b10), mk_user(1, 8'h61, 2'b10), 12'h003, 1, 8'h20,  1,  1, 16'hB090};
      tbl[2]  = '{mk_user(1, 8'hE6, 2'b01), mk_user(1, 8'hE6, 2'b01), 12'h002, 2, 8'h30,  1,  1, 16'hF308};
      tbl[3]  = '{mk_user(1, 8'h19, 2'b10), mk_user(1, 8'h19, 2'b10), 12'h003, 3, 8'h50, -1, -1, 16'h0000};
      tbl[4]  = '{mk_user(1, 8'h19, 2'b01), mk_user(1, 8'h19, 2'b01), 12'h02A, 2, 8'h60,  2, -1, 16'h002A};
      tbl[5]  = '{mk_user(1, 8'h07, 2'b01), mk_user(1, 8'h07, 2'b01), 12'h03C, 1, 8'h70,  3, -1, 16'h003C};
      tbl[6]  = '{mk_user(1, 8'hD5, 2'b01), mk_user(1, 8'hD5, 2'b01), 12'hABC, 1, 8'h80,  0,  0, 16'h0ABC};
      tbl[7]  = '{mk_user(1, 8'hD5, 2'b10), mk_user(1, 8'hD5, 2'b10), 12'h001, 1, 8'h90, -1, -1, 16'h0000};
      tbl[8]  = '{mk_user(0, 8'hD5, 2'b01), mk_user(0, 8'hD5, 2'b01), 12'h002, 2, 8'hA0, -1, -1, 16'h0000};
      tbl[9]  = '{mk_user(1, 8'h55, 2'b01), mk_user(1, 8'h55, 2'b01), 12'h001, 1, 8'hB0, -1, -1, 16'h0000};
      tbl[10] = '{mk_user(1, 8'h2A, 2'b00), mk_user(1, 8'h2A, 2'b00), 12'h001, 1, 8'hC0, -1, -1, 16'h0000};
      tbl[11] = '{mk_user(1, 8'h9E, 2'b11), mk_user(1, 8'h9E, 2'b11), 12'h001, 1, 8'hD0, -1, -1, 16'h0000};
      tbl[12] = '{mk_user(1, 8'hD5, 2'b01), mk_user(1, 8'h07, 2'b01), 12'h003, 3, 8'hE0,  0,  0, 16'h0003};
      tbl[13] = '{mk_user(1, 8'h4C, 2'b10), mk_user(1, 8'h4C, 2'b10), 12'h007, 1, 8'hF0,  1,  1, 16'hA610};
      tbl[14] = '{mk_user(1, 8'hD5, 2'b01), mk_user(1, 8'hD5, 2'b01), 12'h001, 1, 8'h11,  0,  0, 16'h0001};

      rst = 1'b1;
      idle_in();
      if4.i_ch_axis_ready = 4'hF;
      step();
      step();
      chk_out4("reset", -1, 8'h00, 16'h0000, 1'b0);
      chk("reset valid2", 64'(if2.o_ch_axis_valid), 64'd0);
      chk("reset drop4", 64'(drop4), 64'd0);
      chk("reset ready4", 64'(if4.o_rx_axis_ready), 64'd1);
      rst = 1'b0;
      step();

      // Reset in the middle of an E frame, then a P frame must land on channel 1.
      drive(mk_user(1, 8'hD5, 2'b01), 12'h003, 8'h5A, 1'b0);
      step();
      drive(mk_user(1, 8'hD5, 2'b01), 12'h003, 8'h5B, 1'b0);
      step();
      chk_out4("pre-reset", 0, 8'h5B, 16'h0003, 1'b0);
      rst = 1'b1;
      idle_in();
      step();
      chk_out4("mid-reset", -1, 8'h00, 16'h0000, 1'b0);
      chk("mid-reset valid2", 64'(if2.o_ch_axis_valid), 64'd0);
      rst = 1'b0;
      step();
      send(1);
      idle_in();
      step();

      for (int vi = 0; vi < 15; vi++)
         send(vi);
      idle_in();
      step();

      // P frame with channel 1 stalled for three cycles after its first beat.
      pu = mk_user(1, 8'h61, 2'b10);
      drive(pu, 12'h005, 8'h40, 1'b0);
      step();
      chk_out4("bp b0", 1, 8'h40, 16'hB090, 1'b0);
      drive(pu, 12'h005, 8'h41, 1'b0);
      if4.i_ch_axis_ready = 4'b1101;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk($sformatf("bp stall%0d ready4", j), 64'(if4.o_rx_axis_ready), 64'd0);
         chk($sformatf("bp stall%0d ready2", j), 64'(if2.o_rx_axis_ready), 64'd0);
         step();
         chk_out4($sformatf("bp stall%0d", j), 1, 8'h40, 16'hB090, 1'b0);
      end
      if4.i_ch_axis_ready = 4'hF;
      #1;
      chk("bp release ready4", 64'(if4.o_rx_axis_ready), 64'd1);
      step();
      chk_out4("bp b1", 1, 8'h41, 16'hB090, 1'b0);
      drive(pu, 12'h005, 8'h42, 1'b0);
      step();
      chk_out4("bp b2", 1, 8'h42, 16'hB090, 1'b0);
      drive(pu, 12'h005, 8'h43, 1'b1);
      step();
      chk_out4("bp b3", 1, 8'h43, 16'hB090, 1'b1);
      chk("bp valid2", 64'(if2.o_ch_axis_valid), 64'd2);
      idle_in();
      step();
      chk_out4("drained", -1, 8'h00, 16'h0000, 1'b0);
      step();
      step();

`ifdef QBU_RX_ROUTER_STATS_EN
      chk("frm4 ch0", 64'(frm4[31:0]), 64'(exp_frm4_0));
      chk("frm2 ch0", 64'(frm2[31:0]), 64'(exp_frm2_0));
      chk("drop4 cnt", 64'(dcnt4), 64'(exp_drop4));
      chk("drop2 cnt", 64'(dcnt2), 64'(exp_drop2));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
